// File: rtl/compound_out_arbiter.sv
// Two-requester round-robin arbiter feeding one holding register toward a shared consumer.
// Optional build macro COMPOUND_OUT_ARBITER_WRITE_PRIO_EN: on a tie with differing modes, the write requester wins.

package testbasic17_types;

    typedef enum logic {
        read  = 1'b0,
        write = 1'b1
    } mode_t;

    typedef struct packed {
        mode_t      mode;
        logic [7:0] x;
        logic [7:0] y;
    } CompoundType;

endpackage

module compound_out_arbiter
    import testbasic17_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  CompoundType      a_in,
    input  logic             a_in_notify,
    output logic             a_in_sync,

    input  CompoundType      b_in,
    input  logic             b_in_notify,
    output logic             b_in_sync,

    output CompoundType      m_out,
    output logic             m_out_notify,
    input  logic             m_out_sync,

    output logic [CNT_W-1:0] xfer_cnt,
    output logic             last_grant
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FULL = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam CompoundType      HOLD_RST  = '{mode: read, x: 8'd0, y: 8'd0};

    logic [0:0]       state_q, state_d;
    CompoundType      hold_q,  hold_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             last_q,  last_d;

    logic slot_free;
    logic any_req;
    logic winner_b;
    logic accept;
    logic xfer_done;

    // Winner selection: a lone requester wins; a tie goes to whoever was not granted last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        winner_b = 1'b0;
        unique case ({a_in_notify, b_in_notify})
            2'b01:   winner_b = 1'b1;
            2'b11: begin
`ifdef COMPOUND_OUT_ARBITER_WRITE_PRIO_EN
                if (a_in.mode != b_in.mode) begin
                    winner_b = (b_in.mode == write);
                end else begin
                    winner_b = ~last_q;
                end
`else
                winner_b = ~last_q;
`endif
            end
            default: winner_b = 1'b0;
        endcase
    end

    // The slot is free when empty, or when the consumer drains it this very cycle.
    always_comb begin
        slot_free = (state_q == IDLE) || ((state_q == FULL) && m_out_sync);
        any_req   = a_in_notify || b_in_notify;
        accept    = !rst && slot_free && any_req;
        xfer_done = (state_q == FULL) && m_out_sync;
        a_in_sync = accept && !winner_b;
        b_in_sync = accept && winner_b;
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        if (xfer_done) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (accept) begin
            hold_d  = winner_b ? b_in : a_in;
            last_d  = winner_b;
            state_d = FULL;
        end else if (xfer_done) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= HOLD_RST;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign m_out        = hold_q;
    assign m_out_notify = (state_q == FULL);
    assign xfer_cnt     = cnt_q;
    assign last_grant   = last_q;

endmodule

// File: doc/compound_out_arbiter.md
COMPOUND_OUT_ARBITER -- requirements
Module: compound_out_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the completed-transfer counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port a_in  input  CompoundType  requester A payload (mode, x, y from testbasic17_types).
REQ-005 SHALL have port a_in_notify  input  1  requester A offers a_in.
REQ-006 SHALL have port a_in_sync  output  1  requester A payload accepted this cycle.
REQ-007 SHALL have ports b_in, b_in_notify, b_in_sync, identical in form to REQ-004..006, for requester B.
REQ-008 SHALL have port m_out  output  CompoundType  arbitrated payload to the shared consumer.
REQ-009 SHALL have port m_out_notify  output  1  m_out valid.
REQ-010 SHALL have port m_out_sync  input  1  consumer ready.
REQ-011 SHALL have port xfer_cnt  output  CNT_W  count of completed m_out transfers.
REQ-012 SHALL have port last_grant  output  1  0 = A, 1 = B; requester granted most recently.

Function
REQ-013 SHALL treat a transfer as complete on any cycle with m_out_notify=1 and m_out_sync=1; likewise an input is accepted on any cycle with X_in_notify=1 and X_in_sync=1.
REQ-014 SHALL implement FSM with two states: IDLE (holding register empty) and FULL (holding register valid).
REQ-015 SHALL define slot_free = (state==IDLE) or (state==FULL and m_out_sync=1).
REQ-016 SHALL drive a_in_sync and b_in_sync combinationally: 1 only for the winner, only when slot_free=1 and the winner's notify=1; at most one is 1 per cycle.
REQ-017 SHALL pick the winner round-robin: single request wins; with both requesting, the requester not equal to last_grant wins.
REQ-018 SHALL, on acceptance, load the payload into the holding register, set last_grant to the winner, and enter/stay in FULL on the next edge.
REQ-019 SHALL, in FULL with m_out_sync=1 and no acceptance, return to IDLE; with acceptance, stay FULL with the new payload (one transfer per cycle sustained).
REQ-020 SHALL, in FULL with m_out_sync=0, hold m_out stable, keep m_out_notify=1, and keep both in_sync at 0.
REQ-021 SHALL drive m_out from the holding register and m_out_notify=1 exactly when state==FULL; latency from acceptance to m_out_notify is 1 cycle.
REQ-022 SHALL increment xfer_cnt by 1 per completed transfer, wrapping from 2^CNT_W-1 to 0.
REQ-023 SHALL leave m_out payload fields unchanged in IDLE (last value or reset value).

Reset
REQ-024 SHALL on rst=1: state IDLE, m_out_notify=0, m_out.mode=read, m_out.x=0, m_out.y=0, xfer_cnt=0, last_grant=1 (A wins first tie).
REQ-025 SHALL hold a_in_sync=0 and b_in_sync=0 while rst=1.
REQ-026 SHALL discard any held payload when rst asserts mid-transfer; no transfer is counted on that cycle.

Configuration
REQ-027 SHALL, with macro COMPOUND_OUT_ARBITER_WRITE_PRIO_EN defined, grant to the sole requester whose payload mode==write when both request and modes differ, overriding round-robin; last_grant still updates to the winner.
REQ-028 SHALL, without COMPOUND_OUT_ARBITER_WRITE_PRIO_EN, use pure round-robin per REQ-017.

Verification
REQ-029 Reset, then a_in={write,5,1}, a_in_notify=1 one cycle, m_out_sync=1 -> a_in_sync=1 that cycle, next cycle m_out={write,5,1}, notify=1, xfer_cnt=1 after edge, then IDLE.
REQ-030 Both notify=1 continuously, m_out_sync=1 -> grants A,B,A,B...; one transfer per cycle; xfer_cnt=4 after 4 transfers.
REQ-031 FULL with m_out_sync=0 for 3 cycles, b_in_notify=1 -> m_out stable, b_in_sync=0 for 3 cycles; m_out_sync=1 -> B accepted same cycle.
REQ-032 Macro defined, last_grant=1, a_in.mode=read, b_in.mode=write, both request -> B wins; macro undefined -> A wins.
REQ-033 rst=1 while FULL with x=7 -> next cycle m_out_notify=0, m_out.x=0, xfer_cnt=0, last_grant=1.
REQ-034 CNT_W=4, 17 transfers -> xfer_cnt wraps 15->0, final value 1.
